// File: rtl/byte_serializer_if.sv
// Parallel word handshake into the byte serializer.
// Upstream drives valid/data; the serializer returns ready.
interface byte_serializer_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial byte shifter with frame-start marking and idle gap.
// Optional even parity bit per frame: define BYTE_SERIALIZER_PARITY_EN.
module byte_serializer #(
   parameter int DATA_W     = 8,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   byte_serializer_if.slave    up,
   output logic                ser_out,
   output logic                ser_valid,
   output logic                frame_start,
   output logic                busy
);

`ifdef BYTE_SERIALIZER_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam int CW = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   state_t               state_q, state_d;
   logic [FRAME_LEN-1:0] sr_q, sr_d, frame;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           gap_q, gap_d;
   logic [DATA_W-1:0]    ord;
   logic                 rdy_q;
   logic                 accept;

   // Reorder so the first bit on the wire always sits at the top of sr.
   always_comb begin
      ord = '0;
      for (int i = 0; i < DATA_W; i++) begin
         ord[i] = (MSB_FIRST != 0) ? up.in_data[i]
                                   : up.in_data[DATA_W-1-i];
      end
   end

`ifdef BYTE_SERIALIZER_PARITY_EN
   assign frame = {ord, ^up.in_data};
`else
   assign frame = ord;
`endif

   assign accept      = (state_q == IDLE) && rdy_q && up.in_valid;
   assign up.in_ready = rdy_q;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               sr_d    = frame;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
               sr_d    = '0;
               cnt_d   = '0;
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               sr_d  = sr_q << 1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_q == 4'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         rdy_q       <= 1'b0;
         busy        <= 1'b0;
         ser_valid   <= 1'b0;
         ser_out     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         rdy_q       <= (state_d == IDLE);
         busy        <= (state_d != IDLE);
         ser_valid   <= (state_d == SHIFT);
         ser_out     <= (state_d == SHIFT) && sr_d[FRAME_LEN-1];
         frame_start <= accept;
      end
   end

endmodule
